// File: rtl/psum_accumulator_if.sv
// Operand-pair and partial-sum handshake bundle for psum_accumulator.
// The master side is the upstream checker plus the downstream sum consumer.
interface psum_accumulator_if #(
    parameter int IF_CELL_SIZE     = 8,
    parameter int FILTER_CELL_SIZE = 8,
    parameter int PSUM_SIZE        = 20,
    parameter int PSUM_ADDR_SIZE   = 2
);
    logic                               can_mult;
    logic                               par_done;
    logic signed [IF_CELL_SIZE-1:0]     if_data;
    logic signed [FILTER_CELL_SIZE-1:0] filter_data;
    logic                               mac_ready;
    logic signed [PSUM_SIZE-1:0]        psum_out;
    logic                               psum_valid;
    logic                               psum_ready;
    logic [PSUM_ADDR_SIZE:0]            psum_count;
    logic                               overflow;

    modport master (
        output can_mult, par_done, if_data, filter_data, psum_ready,
        input  mac_ready, psum_out, psum_valid, psum_count, overflow
    );

    modport slave (
        input  can_mult, par_done, if_data, filter_data, psum_ready,
        output mac_ready, psum_out, psum_valid, psum_count, overflow
    );
endinterface

// File: rtl/psum_accumulator.sv
// Two-stage multiply-accumulate that commits each finished filter-window sum
// into a small circular scratchpad drained through a valid/ready handshake.
module psum_accumulator #(
    parameter int IF_CELL_SIZE     = 8,
    parameter int FILTER_CELL_SIZE = 8,
    parameter int PSUM_SIZE        = 20,
    parameter int PSUM_DEPTH       = 4,
    parameter int PSUM_ADDR_SIZE   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    psum_accumulator_if.slave bus
);
    localparam int PROD_SIZE = IF_CELL_SIZE + FILTER_CELL_SIZE;
    localparam logic [PSUM_ADDR_SIZE-1:0] PTR_ONE   = PSUM_ADDR_SIZE'(1);
    localparam logic [PSUM_ADDR_SIZE:0]   CNT_ONE   = (PSUM_ADDR_SIZE+1)'(1);
    localparam logic [PSUM_ADDR_SIZE:0]   CNT_ZERO  = (PSUM_ADDR_SIZE+1)'(0);
    localparam logic [PSUM_ADDR_SIZE+1:0] OCC_LIMIT = (PSUM_ADDR_SIZE+2)'(PSUM_DEPTH);

    // Signed overflow of a two's-complement add: equal operand signs, differing result sign.
    function automatic logic add_overflow(
        input logic signed [PSUM_SIZE-1:0] a,
        input logic signed [PSUM_SIZE-1:0] b,
        input logic signed [PSUM_SIZE-1:0] s
    );
        add_overflow = (a[PSUM_SIZE-1] == b[PSUM_SIZE-1]) && (s[PSUM_SIZE-1] != a[PSUM_SIZE-1]);
    endfunction

    logic signed [PROD_SIZE-1:0]   r_p1;
    logic                          r_v1;
    logic                          r_last1;
    logic signed [PSUM_SIZE-1:0]   r_acc;
    logic signed [PSUM_SIZE-1:0]   r_mem [PSUM_DEPTH];
    logic [PSUM_ADDR_SIZE-1:0]     r_wr_ptr;
    logic [PSUM_ADDR_SIZE-1:0]     r_rd_ptr;
    logic [PSUM_ADDR_SIZE:0]       r_count;
    logic                          r_overflow;

    logic [PSUM_ADDR_SIZE+1:0]     w_occupancy;
    logic                          w_mac_ready;
    logic                          w_accept;
    logic                          w_push;
    logic                          w_pop;
    logic signed [PROD_SIZE-1:0]   w_product;
    logic signed [PSUM_SIZE-1:0]   w_p1_ext;
    logic signed [PSUM_SIZE-1:0]   w_sum;

    // Handshake decode and datapath arithmetic; the pending commit counts as occupied.
    always_comb begin
        w_occupancy = {1'b0, r_count} + {{(PSUM_ADDR_SIZE+1){1'b0}}, (r_v1 & r_last1)};
        w_mac_ready = (w_occupancy < OCC_LIMIT);
        w_accept    = bus.can_mult & w_mac_ready;
        w_push      = r_v1 & r_last1;
        w_pop       = (r_count != CNT_ZERO) & bus.psum_ready;
        w_product   = PROD_SIZE'(bus.if_data) * PROD_SIZE'(bus.filter_data);
        w_p1_ext    = PSUM_SIZE'(r_p1);
        w_sum       = r_acc + w_p1_ext;
    end

    // Stage 1: register the product of an accepted pair and its end-of-window tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1    <= {PROD_SIZE{1'b0}};
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
        end else if (w_accept) begin
            r_p1    <= w_product;
            r_v1    <= 1'b1;
            r_last1 <= bus.par_done;
        end else begin
            r_v1    <= 1'b0;
        end
    end

    // Stage 2: accumulate, restarting from zero after a commit; overflow is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= {PSUM_SIZE{1'b0}};
            r_overflow <= 1'b0;
        end else if (r_v1) begin
            r_acc      <= r_last1 ? {PSUM_SIZE{1'b0}} : w_sum;
            r_overflow <= r_overflow | add_overflow(r_acc, w_p1_ext, w_sum);
        end else begin
            r_acc      <= r_acc;
            r_overflow <= r_overflow;
        end
    end

    // Scratchpad storage; the wrapped sum is stored even when it overflowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PSUM_DEPTH; i++) begin
                r_mem[i] <= {PSUM_SIZE{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_sum;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Circular pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PSUM_ADDR_SIZE{1'b0}};
            r_rd_ptr <= {PSUM_ADDR_SIZE{1'b0}};
            r_count  <= CNT_ZERO;
        end else begin
            r_wr_ptr <= w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.mac_ready  = w_mac_ready;
    assign bus.psum_out   = r_mem[r_rd_ptr];
    assign bus.psum_valid = (r_count != CNT_ZERO);
    assign bus.psum_count = r_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed vector table, corner sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_psum_accumulator;
    localparam int IFW   = 8;
    localparam int FW    = 8;
    localparam int PW    = 20;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    psum_accumulator_if #(.IF_CELL_SIZE(IFW), .FILTER_CELL_SIZE(FW),
                          .PSUM_SIZE(PW), .PSUM_ADDR_SIZE(AW)) bus ();

    psum_accumulator #(.IF_CELL_SIZE(IFW), .FILTER_CELL_SIZE(FW), .PSUM_SIZE(PW),
                       .PSUM_DEPTH(DEPTH), .PSUM_ADDR_SIZE(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit cm; bit pd; int ifd; int fd; bit pr;
        bit e_valid; int e_count; int e_out; bit e_ready;
    } vec_t;
    vec_t tbl[$];

    // reference model state
    longint m_acc;
    longint m_q[$];
    bit     m_pv, m_pl, m_ovf;
    longint m_pp;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit cm, input bit pd, input int ifd, input int fd, input bit pr,
                       input bit ev, input int ec, input int eo, input bit er);
        vec_t v;
        v.cm = cm; v.pd = pd; v.ifd = ifd; v.fd = fd; v.pr = pr;
        v.e_valid = ev; v.e_count = ec; v.e_out = eo; v.e_ready = er;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit cm, input bit pd, input int ifd, input int fd, input bit pr);
        bus.can_mult    = cm;
        bus.par_done    = pd;
        bus.if_data     = ifd[IFW-1:0];
        bus.filter_data = fd[FW-1:0];
        bus.psum_ready  = pr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit cm, input bit pd, input int ifd, input int fd, input bit pr);
        drive(cm, pd, ifd, fd, pr);
        tick();
    endtask

    task automatic check_outs(input string tag, input bit ev, input int ec, input int eo, input bit er);
        chk({tag, "_valid"}, bus.psum_valid, ev);
        chk({tag, "_count"}, bus.psum_count, ec);
        if (ev) chk({tag, "_out"}, bus.psum_out, eo);
        chk({tag, "_ready"}, bus.mac_ready, er);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, bus.psum_valid, 0);
        chk({tag, "_count"}, bus.psum_count, 0);
        chk({tag, "_ready"}, bus.mac_ready, 1);
        chk({tag, "_ovf"},   bus.overflow, 0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b0;
        #3;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    function automatic longint wrap_psum(input longint x);
        longint m, t;
        m = longint'(1) << PW;
        t = x % m;
        if (t < 0) t += m;
        if (t >= m / 2) t -= m;
        return t;
    endfunction

    initial begin
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b0;
        #12;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single window (2,3),(-1,4),(5,5) -> 27
        add(1,0, 2,3,1,  0,0,0,1);
        add(1,0,-1,4,1,  0,0,0,1);
        add(1,1, 5,5,1,  0,0,0,1);
        add(0,0, 0,0,1,  1,1,27,1);
        add(0,0, 0,0,1,  0,0,0,1);
        // par_done without can_mult is ignored
        add(0,1, 9,9,0,  0,0,0,1);
        add(0,0, 0,0,0,  0,0,0,1);
        // fill and stall with the consumer blocked
        add(1,1, 3,1,0,  0,0,0,1);
        add(1,1, 4,1,0,  1,1,3,1);
        add(1,1, 5,1,0,  1,2,3,1);
        add(1,1, 6,1,0,  1,3,3,0);
        add(1,1, 7,1,0,  1,4,3,0);
        add(1,1, 7,1,0,  1,4,3,0);
        add(1,1, 7,1,1,  1,3,4,1);
        add(1,1, 7,1,0,  1,3,4,0);
        add(0,0, 0,0,0,  1,4,4,0);
        add(0,0, 0,0,1,  1,3,5,1);
        add(0,0, 0,0,1,  1,2,6,1);
        add(0,0, 0,0,1,  1,1,7,1);
        add(0,0, 0,0,1,  0,0,0,1);

        foreach (tbl[i]) begin
            cyc(tbl[i].cm, tbl[i].pd, tbl[i].ifd, tbl[i].fd, tbl[i].pr);
            check_outs($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_count,
                       tbl[i].e_out, tbl[i].e_ready);
        end

        // simultaneous push and pop at count 2, across the pointer wrap
        cyc(1, 1, 10, 1, 0);
        cyc(1, 1, 11, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check_outs("pp_fill", 1, 2, 10, 1);
        cyc(1, 1, 12, 1, 0);
        cyc(0, 0, 0, 0, 1);
        check_outs("pp_both1", 1, 2, 11, 1);
        cyc(1, 1, 13, 1, 1);
        check_outs("pp_pop", 1, 1, 12, 1);
        cyc(0, 0, 0, 0, 1);
        check_outs("pp_both2", 1, 1, 13, 1);
        cyc(0, 0, 0, 0, 1);
        check_outs("pp_empty", 0, 0, 0, 1);

        // overflow: 33 x (127*127) = 532257 wraps to -516319
        for (int i = 0; i < 33; i++) cyc(1, (i == 32), 127, 127, 0);
        chk("ovf_before_commit", bus.overflow, 0);
        cyc(0, 0, 0, 0, 0);
        check_outs("ovf_commit", 1, 1, -516319, 1);
        chk("ovf_flag", bus.overflow, 1);
        cyc(0, 0, 0, 0, 1);
        chk("ovf_sticky", bus.overflow, 1);
        chk("ovf_drain", bus.psum_count, 0);

        // reset mid-window discards the partial sum and the in-flight product
        cyc(1, 0, 10, 10, 0);
        cyc(1, 0, 10, 10, 0);
        #2;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cyc(1, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check_outs("midrst_win", 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 1);
        check_outs("midrst_pop", 0, 0, 0, 1);

        // randomized traffic against the reference model
        do_reset();
        m_acc = 0; m_q.delete(); m_pv = 0; m_pl = 0; m_pp = 0; m_ovf = 0;
        for (int c = 0; c < 600; c++) begin
            bit cm, pd, pr, exp_ready, acc_ok, pop;
            int ifd, fd;
            longint full, w;
            cm = ($urandom_range(0, 3) != 0);
            pr = ($urandom_range(0, 2) != 0);
            if (c < 300) begin
                pd  = ($urandom_range(0, 3) == 0);
                ifd = int'($urandom_range(0, 255)) - 128;
                fd  = int'($urandom_range(0, 255)) - 128;
            end else begin
                pd  = ($urandom_range(0, 39) == 0);
                ifd = ($urandom_range(0, 1) != 0) ? 127 : -128;
                fd  = ifd;
            end
            drive(cm, pd, ifd, fd, pr);
            exp_ready = ((m_q.size() + ((m_pv && m_pl) ? 1 : 0)) < DEPTH);
            chk("rnd_mac_ready", bus.mac_ready, exp_ready);
            acc_ok = cm && exp_ready;
            pop    = (m_q.size() > 0) && pr;
            tick();
            if (pop) void'(m_q.pop_front());
            if (m_pv) begin
                full = m_acc + m_pp;
                w    = wrap_psum(full);
                if (full != w) m_ovf = 1'b1;
                if (m_pl) begin
                    m_q.push_back(w);
                    m_acc = 0;
                end else begin
                    m_acc = w;
                end
            end
            m_pv = acc_ok;
            if (acc_ok) begin
                m_pp = longint'(ifd) * longint'(fd);
                m_pl = pd;
            end
            chk("rnd_count", bus.psum_count, m_q.size());
            chk("rnd_valid", bus.psum_valid, (m_q.size() != 0));
            if (m_q.size() != 0) chk("rnd_out", bus.psum_out, m_q[0]);
            chk("rnd_ovf", bus.overflow, m_ovf);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Partial-sum accumulation stage that sits directly downstream of the convolution checker/address stage. It consumes each IF×filter operand pair released when the checker raises `can_mult`. It multiplies and accumulates the products of one filter window, and commits the finished partial sum into a small circular scratchpad when `par_done` marks the window's last product. Finished sums leave through a valid/ready handshake. `mac_ready` provides back-pressure so the upstream stage holds its pointers while the scratchpad is full.

## Interface
- IF_CELL_SIZE, 8, width of a signed input-feature element
- FILTER_CELL_SIZE, 8, width of a signed filter element
- PSUM_SIZE, 20, width of the signed accumulator and of each scratchpad entry; must be ≥ IF_CELL_SIZE+FILTER_CELL_SIZE
- PSUM_DEPTH, 4, scratchpad entries; power of two, ≥ 2
- PSUM_ADDR_SIZE, 2, log2(PSUM_DEPTH)

Clock and reset (already decided): one clock; reset is asynchronous and active-low.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- can_mult  in  1  operand pair valid this cycle
- par_done  in  1  current pair is the last of its window; sampled only when a pair is accepted
- if_data  in  IF_CELL_SIZE  signed IF element
- filter_data  in  FILTER_CELL_SIZE  signed filter element
- mac_ready  out  1  block can accept a pair this cycle
- psum_out  out  PSUM_SIZE  head-of-scratchpad partial sum
- psum_valid  out  1  scratchpad non-empty
- psum_ready  in  1  consumer takes the head entry
- psum_count  out  PSUM_ADDR_SIZE+1  entries currently stored
- overflow  out  1  sticky signed-overflow flag

## Operation
- Accept: a pair is accepted when `can_mult && mac_ready`. Stage 1 registers `p1 = if_data*filter_data` (signed, full width), `v1 <= 1`, and `last1 <= par_done`. With no acceptance, `v1 <= 0`.
- `par_done` with `can_mult=0` is ignored. Pairs presented while `mac_ready=0` are ignored, and upstream must hold them.
- Stage 2, when `v1` is set:
  - Compute `sum = acc + sext(p1)`, modulo 2^PSUM_SIZE.
  - If `last1=0`: `acc <= sum`.
  - If `last1=1`: write `sum` to `mem[wr_ptr]`, increment `wr_ptr` (wraps mod PSUM_DEPTH), and set `acc <= 0`.
- Overflow: signed overflow in the stage-2 add sets `overflow`. It stays set until reset, and the wrapped value is still stored.
- Read side:
  - `psum_valid = (psum_count != 0)` and `psum_out = mem[rd_ptr]`.
  - A pop happens when `psum_valid && psum_ready`; it advances `rd_ptr`, which wraps.
  - `psum_out` is don't-care while `psum_valid=0`.
- Count update: a push alone gives +1, a pop alone gives −1, and push and pop in the same cycle leave the count unchanged. Pop-on-empty is impossible.
- Back-pressure: `mac_ready = (psum_count + (v1 & last1)) < PSUM_DEPTH`. It is computed combinationally from registers only, with no path from `can_mult`. This guarantees a push never meets a full scratchpad.

## Timing
- Reset values:
  - `acc`, `p1`, `v1`, `last1`, `wr_ptr`, `rd_ptr`, `psum_count`, `overflow` are all 0.
  - After reset, `psum_valid=0`, `mac_ready=1`, and `psum_out` is don't-care.
- Latency: a pair accepted at edge E0 reaches the accumulator or scratchpad at E1. For a last pair, `psum_valid` rises after E1 if the scratchpad was empty.
- Throughput: one pair per cycle, with back-to-back windows at no gap; `acc` restarts from 0 on the cycle after a commit.
- Reset asserted mid-window discards the partial `acc`, the in-flight stage-1 pair, and all stored sums immediately, without waiting for a clock.
- Full boundary: `mac_ready` falls once `psum_count` plus a pending commit equals PSUM_DEPTH. A pop in a cycle lowers `psum_count` at the next edge, so `mac_ready` rises one cycle after that pop.

## Test plan
- **Single window:** pairs (2,3), (−1,4), (5,5) on consecutive cycles, `par_done` on the third, `psum_ready=1` → `psum_out=27` and `psum_valid=1` one cycle after the third acceptance edge; `psum_count` returns to 0 after the pop.
- **Fill/stall with PSUM_DEPTH=4, psum_ready=0:** five 1-pair windows (3,1)…(7,1), each with `par_done`:
  - four are accepted;
  - `mac_ready=0` while the 5th is held;
  - `psum_count=4`;
  - one pop (`psum_out=3`) → `mac_ready=1` next cycle, the 5th is accepted, and the order 4,5,6,7 is preserved.
- **Simultaneous push/pop at psum_count=2** → count stays 2, and the FIFO order is correct across the `wr_ptr`/`rd_ptr` wrap.
- **Overflow:** 33 pairs of (127,127), `par_done` on the last → stored `psum_out = −516319` (532257 wrapped at 20 bits) and `overflow=1`, which persists until `rst_n=0`.
- **Reset mid-window:** two pairs (10,10) accepted, pulse `rst_n` low, then window (1,1) with `par_done` → `psum_out=1`; all outputs are at their reset values during reset.
- **Ignored inputs:**
  - `par_done=1` with `can_mult=0` creates no commit;
  - a pair presented while `mac_ready=0` changes neither `acc` nor `psum_count`.
